// File: rtl/sbuf_queue_pointers.sv
// sbuf_queue_pointers: per-queue one-hot head/tail pointers, non-empty flag
// and last-entry flag for the multi-queue shared buffer. The parent owns the
// data memory, the free-slot allocator and the next-pointer linked list.
// Optional build macro: SBUF_PNT_ASSERT_EN compiles in simulation-only
// protocol and pointer-shape assertions.

// and_or_mux: one-hot AND-OR selector. The output is 0 when nothing is selected.
module and_or_mux #(
  parameter int N  = 2,
  parameter int DW = 4
) (
  input  logic [N-1:0]    sel_i,
  input  logic [N*DW-1:0] data_i,
  output logic [DW-1:0]   data_o
);

  // OR together every input whose select bit is set
  always_comb begin
    data_o = '0;
    for (int i = 0; i < N; i++) begin
      data_o = data_o | (data_i[i*DW +: DW] & {DW{sel_i[i]}});
    end
  end

endmodule

module sbuf_queue_pointers #(
  parameter int D = 4,
  parameter int Q = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [Q-1:0] push_sel_i,
  input  logic [D-1:0] slot_push_i,
  input  logic         pop_i,
  input  logic [Q-1:0] pop_sel_i,
  input  logic [Q*D-1:0] pnt_linked_to_head_i,
  output logic [Q-1:0] valid_o,
  output logic [Q*D-1:0] q_head_pnt_o,
  output logic [Q*D-1:0] q_tail_pnt_o,
  output logic [Q-1:0] last_entry_o
);

  for (genvar q = 0; q < Q; q++) begin : g_queue
    logic         push_q;
    logic         pop_q;
    logic         last_q;
    logic         valid_r;
    logic [D-1:0] head_r;
    logic [D-1:0] tail_r;
    logic [D-1:0] link_q;
    logic [1:0]   head_sel;
    logic [D-1:0] head_next;
    logic         head_en;
    logic [D-1:0] tail_next;
    logic         tail_en;
    logic         valid_next;

    assign push_q = push_i & push_sel_i[q];
    assign pop_q  = pop_i & pop_sel_i[q];
    assign link_q = pnt_linked_to_head_i[q*D +: D];
    assign last_q = valid_r & (head_r == tail_r);

    // The new slot becomes head when the queue is empty, or when its only
    // entry leaves in the same cycle. The linked successor becomes head on any
    // pop that leaves entries behind. Popping the last entry with no push
    // selects nothing, so the head clears to 0.
    assign head_sel[0] = push_q & (~valid_r | (pop_q & last_q));
    assign head_sel[1] = pop_q & ~last_q;
    assign head_en     = pop_q | (push_q & ~valid_r);

    and_or_mux #(.N(2), .DW(D)) u_head_mux (
      .sel_i  (head_sel),
      .data_i ({link_q, slot_push_i}),
      .data_o (head_next)
    );

    // A push always moves the tail; popping the last entry alone clears it
    and_or_mux #(.N(1), .DW(D)) u_tail_mux (
      .sel_i  (push_q),
      .data_i (slot_push_i),
      .data_o (tail_next)
    );
    assign tail_en = push_q | (pop_q & last_q);

    assign valid_next = push_q | (valid_r & ~(pop_q & last_q));

    // Per-queue pointer and valid registers
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        valid_r <= 1'b0;
        head_r  <= '0;
        tail_r  <= '0;
      end else begin
        valid_r <= valid_next;
        if (head_en) head_r <= head_next;
        if (tail_en) tail_r <= tail_next;
      end
    end

    assign valid_o[q]            = valid_r;
    assign last_entry_o[q]       = last_q;
    assign q_head_pnt_o[q*D +: D] = head_r;
    assign q_tail_pnt_o[q*D +: D] = tail_r;

`ifdef SBUF_PNT_ASSERT_EN
    a_pop_link: assert property (@(posedge clk) disable iff (rst)
      (pop_q && valid_r && !last_q) |-> (link_q != '0))
      else $error("sbuf_queue_pointers: q%0d pop with zero linked pointer", q);

    a_pnt_shape: assert property (@(posedge clk) disable iff (rst)
      $onehot0(head_r) && $onehot0(tail_r))
      else $error("sbuf_queue_pointers: q%0d pointer not one-hot", q);
`endif
  end

`ifdef SBUF_PNT_ASSERT_EN
  a_push_onehot: assert property (@(posedge clk) disable iff (rst)
    push_i |-> ($onehot(push_sel_i) && $onehot(slot_push_i)))
    else $error("sbuf_queue_pointers: push select or slot not one-hot");

  a_pop_legal: assert property (@(posedge clk) disable iff (rst)
    pop_i |-> ($onehot(pop_sel_i) && ((pop_sel_i & valid_o) != '0)))
    else $error("sbuf_queue_pointers: pop not one-hot or queue empty");
`else
  // No checking logic in this build.
`endif

endmodule

// File: tb/tb_sbuf_queue_pointers.sv
// tb_sbuf_queue_pointers: directed vectors; each step queues its expected
// outputs and a monitor on the falling edge pops and compares them.
module tb_sbuf_queue_pointers;

  logic        clk = 1'b0;
  logic        rst;
  logic        push_i;
  logic [3:0]  push_sel_i;
  logic [3:0]  slot_push_i;
  logic        pop_i;
  logic [3:0]  pop_sel_i;
  logic [15:0] pnt_linked_to_head_i;
  logic [3:0]  valid_o;
  logic [15:0] q_head_pnt_o;
  logic [15:0] q_tail_pnt_o;
  logic [3:0]  last_entry_o;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int          id;
    logic [3:0]  v;
    logic [15:0] h;
    logic [15:0] t;
    logic [3:0]  l;
  } exp_t;

  exp_t sb[$];

  sbuf_queue_pointers #(.D(4), .Q(4)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .push_i               (push_i),
    .push_sel_i           (push_sel_i),
    .slot_push_i          (slot_push_i),
    .pop_i                (pop_i),
    .pop_sel_i            (pop_sel_i),
    .pnt_linked_to_head_i (pnt_linked_to_head_i),
    .valid_o              (valid_o),
    .q_head_pnt_o         (q_head_pnt_o),
    .q_tail_pnt_o         (q_tail_pnt_o),
    .last_entry_o         (last_entry_o)
  );

  always #5 clk = ~clk;

  task automatic check(input exp_t e);
    n_tests++;
    if (valid_o !== e.v) begin
      n_fail++;
      $display("FAIL step%0d valid_o got %b exp %b", e.id, valid_o, e.v);
    end
    n_tests++;
    if (q_head_pnt_o !== e.h) begin
      n_fail++;
      $display("FAIL step%0d head got %h exp %h", e.id, q_head_pnt_o, e.h);
    end
    n_tests++;
    if (q_tail_pnt_o !== e.t) begin
      n_fail++;
      $display("FAIL step%0d tail got %h exp %h", e.id, q_tail_pnt_o, e.t);
    end
    n_tests++;
    if (last_entry_o !== e.l) begin
      n_fail++;
      $display("FAIL step%0d last_entry got %b exp %b", e.id, last_entry_o, e.l);
    end
  endtask

  // Monitor: compare queued expectations away from the active edge
  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e);
    end
  end

  task automatic expect_now(input int id, input logic [3:0] v, input logic [15:0] h,
                            input logic [15:0] t, input logic [3:0] l);
    exp_t e;
    e.id = id; e.v = v; e.h = h; e.t = t; e.l = l;
    sb.push_back(e);
  endtask

  task automatic op(input int id,
                    input logic ps, input logic [3:0] psel, input logic [3:0] slot,
                    input logic pp, input logic [3:0] popsel, input logic [15:0] link,
                    input logic [3:0] ev, input logic [15:0] eh, input logic [15:0] et,
                    input logic [3:0] el);
    push_i = ps; push_sel_i = psel; slot_push_i = slot;
    pop_i = pp; pop_sel_i = popsel; pnt_linked_to_head_i = link;
    @(posedge clk);
    #1;
    push_i = 1'b0; pop_i = 1'b0; push_sel_i = '0; pop_sel_i = '0; slot_push_i = '0;
    expect_now(id, ev, eh, et, el);
  endtask

  initial begin
    int budget;
    rst = 1'b1;
    push_i = 1'b0; push_sel_i = '0; slot_push_i = '0;
    pop_i = 1'b0; pop_sel_i = '0; pnt_linked_to_head_i = 16'h4218;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    //  id push sel     slot     pop sel     link      valid    head      tail      last
    op(0,  0, 4'b0000, 4'b0000, 0, 4'b0000, 16'h4218, 4'b0000, 16'h0000, 16'h0000, 4'b0000);
    op(1,  1, 4'b0001, 4'b0001, 0, 4'b0000, 16'h4218, 4'b0001, 16'h0001, 16'h0001, 4'b0001);
    op(2,  1, 4'b0001, 4'b0010, 0, 4'b0000, 16'h4218, 4'b0001, 16'h0001, 16'h0002, 4'b0000);
    op(3,  0, 4'b0000, 4'b0000, 1, 4'b0001, 16'h4212, 4'b0001, 16'h0002, 16'h0002, 4'b0001);
    op(4,  1, 4'b0100, 4'b0100, 0, 4'b0000, 16'h4218, 4'b0101, 16'h0402, 16'h0402, 4'b0101);
    op(5,  1, 4'b0100, 4'b1000, 1, 4'b0100, 16'h4218, 4'b0101, 16'h0802, 16'h0802, 4'b0101);
    op(6,  1, 4'b1000, 4'b0001, 0, 4'b0000, 16'h4218, 4'b1101, 16'h1802, 16'h1802, 4'b1101);
    op(7,  1, 4'b0010, 4'b0100, 1, 4'b1000, 16'h4218, 4'b0111, 16'h0842, 16'h0842, 4'b0111);
    op(8,  1, 4'b0001, 4'b1000, 0, 4'b0000, 16'h4218, 4'b0111, 16'h0842, 16'h0848, 4'b0110);
    op(9,  1, 4'b0001, 4'b0001, 1, 4'b0001, 16'h4218, 4'b0111, 16'h0848, 16'h0841, 4'b0110);
    op(10, 0, 4'b0000, 4'b0000, 1, 4'b0001, 16'h4211, 4'b0111, 16'h0841, 16'h0841, 4'b0111);

    // Mid-cycle async reset with three queues occupied: checked at the
    // falling edge, before any further rising edge
    @(posedge clk);
    #2 rst = 1'b1;
    expect_now(11, 4'b0000, 16'h0000, 16'h0000, 4'b0000);

    // Strobes held during reset have no effect
    op(12, 1, 4'b1000, 4'b0001, 0, 4'b0000, 16'h4218, 4'b0000, 16'h0000, 16'h0000, 4'b0000);
    rst = 1'b0;
    op(13, 1, 4'b0010, 4'b0010, 0, 4'b0000, 16'h4218, 4'b0010, 16'h0020, 16'h0020, 4'b0010);

    budget = 0;
    while (sb.size() > 0 && budget < 10) begin
      @(posedge clk);
      budget++;
    end
    if (sb.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain pending got %0d exp 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
